regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file writeback arbiter.
// Each requester owns a one-entry buffer; one buffered entry per cycle is
// moved into a registered output stage that drives the register file.
//
// Handshake: a request transfers on the rising edge where reqN_valid and
// reqN_ready are both 1. The requester holds reg/data stable while valid is
// high and ready is low. reqN_ready is 1 when bufN is empty or is being
// granted this cycle, and is forced to 0 while rst_n is low.
module regfile_write_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req0_valid,
  input  logic [ADDR_W-1:0]          req0_reg,
  input  logic [DATA_W-1:0]          req0_data,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [ADDR_W-1:0]          req1_reg,
  input  logic [DATA_W-1:0]          req1_data,
  output logic                       req1_ready,
  output logic [ADDR_W-1:0]          Write_Reg,
  output logic [DATA_W-1:0]          Write_Data,
  output logic                       RegWrite,
  output logic [(1<<ADDR_W)-1:0]     busy,
  output logic                       grant_id
);

  // Requester buffers. r_youngN means bufN was accepted after the entry
  // currently held in the other buffer; it orders same-register writes.
  logic              r_v0, r_v1;
  logic [ADDR_W-1:0] r_reg0, r_reg1;
  logic [DATA_W-1:0] r_data0, r_data1;
  logic              r_young0, r_young1;

  // Output stage and round-robin pointer (id of the last granted requester).
  logic              r_out_v;
  logic [ADDR_W-1:0] r_out_reg;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_id;
  logic              r_last_id;

  logic w_g0, w_g1;
  logic w_acc0, w_acc1;
  logic w_same_reg;

  assign w_same_reg = (r_reg0 == r_reg1);

  // Arbitration: single occupant wins; same register goes to the older
  // entry (requester 0 on a tie); otherwise the requester not granted last.
  always_comb begin
    w_g0 = 1'b0;
    w_g1 = 1'b0;
    if (r_v0 && !r_v1) begin
      w_g0 = 1'b1;
    end else if (!r_v0 && r_v1) begin
      w_g1 = 1'b1;
    end else if (r_v0 && r_v1) begin
      if (w_same_reg) begin
        if (r_young0) w_g1 = 1'b1;
        else          w_g0 = 1'b1;
      end else begin
        if (r_last_id) w_g0 = 1'b1;
        else           w_g1 = 1'b1;
      end
    end
  end

  assign req0_ready = rst_n & (~r_v0 | w_g0);
  assign req1_ready = rst_n & (~r_v1 | w_g1);
  assign w_acc0     = req0_valid & req0_ready;
  assign w_acc1     = req1_valid & req1_ready;

  // Buffer 0: load on accept, vacate on grant, track relative age.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v0     <= 1'b0;
      r_reg0   <= '0;
      r_data0  <= '0;
      r_young0 <= 1'b0;
    end else if (w_acc0) begin
      r_v0     <= 1'b1;
      r_reg0   <= req0_reg;
      r_data0  <= req0_data;
      r_young0 <= r_v1 & ~w_g1;
    end else begin
      if (w_g0) r_v0     <= 1'b0;
      if (w_g1) r_young0 <= 1'b0;
    end
  end

  // Buffer 1: mirror of buffer 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1     <= 1'b0;
      r_reg1   <= '0;
      r_data1  <= '0;
      r_young1 <= 1'b0;
    end else if (w_acc1) begin
      r_v1     <= 1'b1;
      r_reg1   <= req1_reg;
      r_data1  <= req1_data;
      r_young1 <= r_v0 & ~w_g0;
    end else begin
      if (w_g1) r_v1     <= 1'b0;
      if (w_g0) r_young1 <= 1'b0;
    end
  end

  // Output stage: capture the granted entry; pointer follows every grant.
  // Reset leaves the pointer at 1 so requester 0 wins the first contest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_v    <= 1'b0;
      r_out_reg  <= '0;
      r_out_data <= '0;
      r_out_id   <= 1'b0;
      r_last_id  <= 1'b1;
    end else begin
      r_out_v <= w_g0 | w_g1;
      if (w_g0) begin
        r_out_reg  <= r_reg0;
        r_out_data <= r_data0;
        r_out_id   <= 1'b0;
        r_last_id  <= 1'b0;
      end else if (w_g1) begin
        r_out_reg  <= r_reg1;
        r_out_data <= r_data1;
        r_out_id   <= 1'b1;
        r_last_id  <= 1'b1;
      end
    end
  end

  assign RegWrite   = r_out_v;
  assign Write_Reg  = r_out_reg;
  assign Write_Data = r_out_data;
  assign grant_id   = r_out_id;

  // Pending-write map decoded from buffers and the live output stage.
  always_comb begin
    busy = '0;
    if (r_v0)    busy[r_reg0]    = 1'b1;
    if (r_v1)    busy[r_reg1]    = 1'b1;
    if (r_out_v) busy[r_out_reg] = 1'b1;
  end

endmodule
